// File: rtl/wb_slave_mux_n_pkg.sv
// Shared types and sizing helpers for the Wishbone 1-to-N slave interconnect.
//   mux_state_e : request FSM states
//   idx_width   : width of a slave index for n slaves (at least 1 bit)
//   tmr_width   : width of a watchdog counter that must reach timeout-1
package wb_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } mux_state_e;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int tmr_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/wb_slave_mux_n_if.sv
// Bus bundle between one Wishbone classic master, the interconnect and N slaves.
// Signal names are written from the interconnect's point of view
// (_i = into the interconnect, _o = out of it).
//   mux    : the interconnect itself
//   master : the master driving the request side
//   slave  : the bank of N slaves on the routed side
interface wb_slave_mux_n_if #(
    parameter int N_SLV = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    logic [AW-1:0]          m_adr_i;
    logic [DW-1:0]          m_dat_i;
    logic [DW/8-1:0]        m_sel_i;
    logic                   m_we_i;
    logic                   m_cyc_i;
    logic                   m_stb_i;
    logic [DW-1:0]          m_dat_o;
    logic                   m_ack_o;
    logic                   m_err_o;

    logic [N_SLV*AW-1:0]    s_adr_o;
    logic [N_SLV*DW-1:0]    s_dat_o;
    logic [N_SLV*DW/8-1:0]  s_sel_o;
    logic [N_SLV-1:0]       s_we_o;
    logic [N_SLV-1:0]       s_cyc_o;
    logic [N_SLV-1:0]       s_stb_o;
    logic [N_SLV*DW-1:0]    s_dat_i;
    logic [N_SLV-1:0]       s_ack_i;
    logic [N_SLV-1:0]       s_err_i;

    modport mux (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        input  s_dat_i, s_ack_i, s_err_i
    );

    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        input  m_dat_o, m_ack_o, m_err_o
    );

    modport slave (
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        output s_dat_i, s_ack_i, s_err_i
    );

endinterface

// File: rtl/wb_slave_mux_n_slot_decode.sv
// Combinational slot decoder: maps the page part of an address (address
// bits above SLOT_BITS) to a slave index.
//   page_i : adr[AW-1:SLOT_BITS]
//   hit_o  : page lies in one of the N_SLV slots starting at BASE_ADDR
//   idx_o  : slot number (meaningful only when hit_o)
module wb_slot_decode
    import wb_mux_pkg::*;
#(
    parameter int              N_SLV     = 4,
    parameter int              AW        = 32,
    parameter logic [AW-1:0]   BASE_ADDR = 32'h3000_0000,
    parameter int              SLOT_BITS = 12,
    parameter int              IDX_W     = idx_width(N_SLV)
) (
    input  logic [AW-SLOT_BITS-1:0] page_i,
    output logic                    hit_o,
    output logic [IDX_W-1:0]        idx_o
);
    localparam int              PW      = AW - SLOT_BITS;
    localparam logic [PW-1:0]   BASE_PG = BASE_ADDR[AW-1:SLOT_BITS];
    localparam logic [PW-1:0]   N_PG    = PW'(N_SLV);

    logic [PW-1:0] diff;

    // Unsigned subtraction: pages below the base wrap to huge values and miss.
    always_comb begin
        diff  = page_i - BASE_PG;
        hit_o = (diff < N_PG);
        idx_o = diff[IDX_W-1:0];
    end

endmodule

// File: rtl/wb_slave_mux_n.sv
// Wishbone classic 1-master -> N-slave interconnect.
// Registers each request, routes it to one slave by address slot, and
// answers with a single-cycle ack or err. Unmapped addresses, slave errors
// and watchdog expiry all produce err; a master dropping cyc abandons the
// access silently.
//   wb_clk_i / wb_rst_i : clock, synchronous active-high reset
//   bus                 : master request/response and per-slave buses
//   to_evt_o            : one-cycle pulse, coincident with m_err_o, when
//                         the watchdog ends an access
//
// state  | meaning
// IDLE   | waiting for cyc&stb; latches the request
// ACCESS | selected slave strobed; waiting for ack/err/timeout/abort
// RESP   | m_ack_o with captured read data for one cycle
// ERR    | m_err_o for one cycle
module wb_slave_mux_n
    import wb_mux_pkg::*;
#(
    parameter int              N_SLV     = 4,
    parameter int              AW        = 32,
    parameter int              DW        = 32,
    parameter logic [AW-1:0]   BASE_ADDR = 32'h3000_0000,
    parameter int              SLOT_BITS = 12,
    parameter int              TIMEOUT   = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    wb_slave_mux_n_if.mux bus,
    output logic          to_evt_o
);
    localparam int             SW       = DW / 8;
    localparam int             IDX_W    = idx_width(N_SLV);
    localparam int             TMR_W    = tmr_width(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    mux_state_e        state_q, state_d;
    logic [AW-1:0]     adr_q, adr_d;
    logic [DW-1:0]     wdat_q, wdat_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic              we_q, we_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [DW-1:0]     rdat_q, rdat_d;
    logic              to_evt_q, to_evt_d;

    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic              slv_ack;
    logic              slv_err;
    logic [DW-1:0]     slv_dat;
    logic [N_SLV-1:0]  strobe;

    wb_slot_decode #(
        .N_SLV     (N_SLV),
        .AW        (AW),
        .BASE_ADDR (BASE_ADDR),
        .SLOT_BITS (SLOT_BITS),
        .IDX_W     (IDX_W)
    ) u_dec (
        .page_i (bus.m_adr_i[AW-1:SLOT_BITS]),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx)
    );

    // Only the selected slave's response lines are ever looked at.
    always_comb begin
        slv_ack = bus.s_ack_i[idx_q];
        slv_err = bus.s_err_i[idx_q];
        slv_dat = bus.s_dat_i[int'(idx_q)*DW +: DW];
    end

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        wdat_d   = wdat_q;
        sel_d    = sel_q;
        we_d     = we_q;
        idx_d    = idx_q;
        tmr_d    = tmr_q;
        rdat_d   = rdat_q;
        to_evt_d = 1'b0;

        case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (bus.m_cyc_i && bus.m_stb_i) begin
                    adr_d   = bus.m_adr_i;
                    wdat_d  = bus.m_dat_i;
                    sel_d   = bus.m_sel_i;
                    we_d    = bus.m_we_i;
                    idx_d   = dec_idx;
                    state_d = dec_hit ? ACCESS : ERR;
                end
            end
            ACCESS: begin
                tmr_d = tmr_q + TMR_W'(1);
                // Abort first: the master is no longer listening for a reply.
                if (!bus.m_cyc_i) begin
                    state_d = IDLE;
                end else if (slv_err) begin
                    state_d = ERR;
                end else if (slv_ack) begin
                    rdat_d  = we_q ? '0 : slv_dat;
                    state_d = RESP;
                end else if ((TIMEOUT != 0) && (tmr_q == TMR_LAST)) begin
                    to_evt_d = 1'b1;
                    state_d  = ERR;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            adr_q    <= '0;
            wdat_q   <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            idx_q    <= '0;
            tmr_q    <= '0;
            rdat_q   <= '0;
            to_evt_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            wdat_q   <= wdat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            idx_q    <= idx_d;
            tmr_q    <= tmr_d;
            rdat_q   <= rdat_d;
            to_evt_q <= to_evt_d;
        end
    end

    always_comb begin
        strobe = '0;
        if (state_q == ACCESS) begin
            strobe[idx_q] = 1'b1;
        end
    end

    assign bus.m_ack_o = (state_q == RESP);
    assign bus.m_err_o = (state_q == ERR);
    assign bus.m_dat_o = (state_q == RESP) ? rdat_q : '0;

    assign bus.s_adr_o = {N_SLV{adr_q}};
    assign bus.s_dat_o = {N_SLV{wdat_q}};
    assign bus.s_sel_o = {N_SLV{sel_q}};
    assign bus.s_we_o  = {N_SLV{we_q}};
    assign bus.s_cyc_o = strobe;
    assign bus.s_stb_o = strobe;

    assign to_evt_o = to_evt_q;

endmodule

// File: tb/tb_wb_slave_mux_n.sv
module tb_wb_slave_mux_n;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_slave_mux_n_if #(.N_SLV(4),  .AW(32), .DW(32)) ifa ();
    wb_slave_mux_n_if #(.N_SLV(16), .AW(32), .DW(32)) ifb ();
    logic evt_a, evt_b;

    wb_slave_mux_n #(.N_SLV(4), .AW(32), .DW(32), .BASE_ADDR(32'h3000_0000),
                     .SLOT_BITS(12), .TIMEOUT(8)) dut_a (
        .wb_clk_i (clk), .wb_rst_i (rst), .bus (ifa), .to_evt_o (evt_a));

    wb_slave_mux_n #(.N_SLV(16), .AW(32), .DW(32), .BASE_ADDR(32'h3000_0000),
                     .SLOT_BITS(12), .TIMEOUT(0)) dut_b (
        .wb_clk_i (clk), .wb_rst_i (rst), .bus (ifb), .to_evt_o (evt_b));

    // Shared stimulus, routed to whichever instance is under test.
    logic [31:0]  m_adr, m_dat;
    logic [3:0]   m_sel;
    logic         m_we, m_cyc, m_stb, use_b;
    logic [511:0] s_dat;
    logic [15:0]  s_ack, s_err;

    assign ifa.m_adr_i = m_adr;
    assign ifa.m_dat_i = m_dat;
    assign ifa.m_sel_i = m_sel;
    assign ifa.m_we_i  = m_we;
    assign ifa.m_cyc_i = m_cyc & ~use_b;
    assign ifa.m_stb_i = m_stb & ~use_b;
    assign ifa.s_dat_i = s_dat[127:0];
    assign ifa.s_ack_i = use_b ? 4'h0 : s_ack[3:0];
    assign ifa.s_err_i = use_b ? 4'h0 : s_err[3:0];

    assign ifb.m_adr_i = m_adr;
    assign ifb.m_dat_i = m_dat;
    assign ifb.m_sel_i = m_sel;
    assign ifb.m_we_i  = m_we;
    assign ifb.m_cyc_i = m_cyc & use_b;
    assign ifb.m_stb_i = m_stb & use_b;
    assign ifb.s_dat_i = s_dat;
    assign ifb.s_ack_i = use_b ? s_ack : 16'h0;
    assign ifb.s_err_i = use_b ? s_err : 16'h0;

    logic [15:0] o_cyc, o_stb;
    logic        o_ack, o_err, o_evt;
    logic [31:0] o_dat;
    assign o_cyc = use_b ? ifb.s_cyc_o : {12'h0, ifa.s_cyc_o};
    assign o_stb = use_b ? ifb.s_stb_o : {12'h0, ifa.s_stb_o};
    assign o_ack = use_b ? ifb.m_ack_o : ifa.m_ack_o;
    assign o_err = use_b ? ifb.m_err_o : ifa.m_err_o;
    assign o_evt = use_b ? evt_b : evt_a;
    assign o_dat = use_b ? ifb.m_dat_o : ifa.m_dat_o;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: what the master should see for one access.
    // mode: 0 ack, 1 err, 2 ack+err together, 3 slave silent.
    // kind: 0 nothing, 1 ack, 2 err. cyc: cycles after the sampling edge.
    task automatic predict(input logic [31:0] adr, input logic we, input int mode, input int dly,
                           output bit hit, output int idx, output int kind, output int cyc,
                           output logic [31:0] dat, output bit evt);
        longint a    = longint'(adr);
        longint base = 64'h3000_0000;
        int     n    = use_b ? 16 : 4;
        int     to   = use_b ? 0 : 8;
        hit = (a >= base) && (a < base + longint'(n) * 4096);
        idx = hit ? int'((a - base) / 4096) : 0;
        evt = 1'b0;
        dat = 32'h0;
        if (!hit) begin
            kind = 2; cyc = 1;
        end else if (mode == 3 || (to != 0 && dly >= to)) begin
            kind = (to != 0) ? 2 : 0;
            cyc  = to + 1;
            evt  = (to != 0);
        end else begin
            kind = (mode == 0) ? 1 : 2;
            cyc  = dly + 2;
            if (mode == 0 && !we) dat = s_dat[idx*32 +: 32];
        end
    endtask

    task automatic txn(input string tag, input logic [31:0] adr, input logic we,
                       input int mode, input int dly, input int budget, input bit noise);
        bit hit, e_evt, o_evt_resp, adr_seen;
        int idx, e_kind, e_cyc, k, ob_kind, ob_cyc, stbcnt, evtcnt, bad, quiet;
        logic [31:0] e_dat, ob_dat, ob_adr;
        predict(adr, we, mode, dly, hit, idx, e_kind, e_cyc, e_dat, e_evt);
        m_adr = adr; m_we = we; m_dat = $urandom; m_sel = 4'($urandom);
        m_cyc = 1'b1; m_stb = 1'b1; s_ack = '0; s_err = '0;
        k = 0; ob_kind = 0; ob_cyc = 0; stbcnt = 0; evtcnt = 0; bad = 0;
        ob_dat = '0; ob_adr = '0; o_evt_resp = 1'b0; adr_seen = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            step();
            s_ack = noise ? (16'($urandom) & ~(16'h1 << idx)) : 16'h0;
            s_err = noise ? (16'($urandom) & ~(16'h1 << idx)) : 16'h0;
            if (hit && o_stb[idx]) begin
                if (!adr_seen) begin
                    ob_adr   = use_b ? ifb.s_adr_o[idx*32 +: 32] : ifa.s_adr_o[idx*32 +: 32];
                    adr_seen = 1'b1;
                end
                if (k == dly && (mode == 0 || mode == 2)) s_ack[idx] = 1'b1;
                if (k == dly && (mode == 1 || mode == 2)) s_err[idx] = 1'b1;
                k++;
            end
            if ($countones(o_cyc) > 1) bad++;
            if (o_stb != o_cyc) bad++;
            if (o_cyc != 16'h0 && (!hit || o_cyc != (16'h1 << idx))) bad++;
            if (o_ack && o_err) bad++;
            if (o_stb != 16'h0) stbcnt++;
            if (o_evt) evtcnt++;
            if (o_ack || o_err) begin
                ob_kind = o_ack ? 1 : 2;
                ob_cyc = c; ob_dat = o_dat; o_evt_resp = o_evt;
                break;
            end
        end
        m_cyc = 1'b0; m_stb = 1'b0; s_ack = '0; s_err = '0;
        step();
        quiet = int'(o_ack) + int'(o_err) + int'(o_evt) + $countones(o_cyc);
        check({tag, ".kind"},   64'(ob_kind), 64'(e_kind));
        check({tag, ".cycle"},  64'(ob_cyc),  64'(e_cyc));
        check({tag, ".data"},   64'(ob_dat),  64'(e_dat));
        check({tag, ".to_evt"}, 64'(o_evt_resp), 64'(e_evt));
        check({tag, ".evtcnt"}, 64'(evtcnt),  64'(e_evt ? 1 : 0));
        check({tag, ".stbcnt"}, 64'(stbcnt),  64'(hit ? e_cyc - 1 : 0));
        check({tag, ".onehot"}, 64'(bad),     64'd0);
        check({tag, ".after"},  64'(quiet),   64'd0);
        if (hit) check({tag, ".s_adr"}, 64'(ob_adr), 64'(adr));
    endtask

    initial begin
        int seen;
        logic [31:0] radr;
        int slot;
        rst = 1'b1; use_b = 1'b0;
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
        s_dat = '0; s_ack = '0; s_err = '0;
        repeat (3) step();
        check("reset_a", {ifa.m_ack_o, ifa.m_err_o, ifa.m_dat_o, ifa.s_cyc_o, ifa.s_stb_o, evt_a,
                          ifa.s_we_o, ifa.s_adr_o[31:0]}, 64'h0);
        check("reset_b", {ifb.m_ack_o, ifb.m_err_o, ifb.m_dat_o, ifb.s_cyc_o, evt_b}, 64'h0);
        rst = 1'b0;
        step();

        // Directed cases on the 4-slot, TIMEOUT=8 instance.
        for (int i = 0; i < 4; i++) s_dat[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
        txn("rd_slot2",     32'h3000_2004, 1'b0, 0, 1, 30, 1'b0);
        txn("wr_unmapped",  32'h3000_4000, 1'b1, 0, 0, 30, 1'b0);
        txn("wr_below",     32'h2FFF_FFFC, 1'b1, 0, 0, 30, 1'b0);
        txn("timeout_s1",   32'h3000_1000, 1'b0, 3, 0, 30, 1'b0);
        txn("ack_at_last",  32'h3000_0008, 1'b0, 0, 7, 30, 1'b0);
        txn("ack_too_late", 32'h3000_0008, 1'b0, 0, 8, 30, 1'b0);
        txn("ack_err_s3",   32'h3000_3010, 1'b0, 2, 0, 30, 1'b0);
        txn("wr_ack_s3",    32'h3000_3FFC, 1'b1, 0, 0, 30, 1'b0);
        txn("top_of_map",   32'h3000_3FFC, 1'b0, 0, 0, 30, 1'b0);

        // Master abort in the third ACCESS cycle.
        m_adr = 32'h3000_1000; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
        step(); step(); step();
        check("abort_stb_before", 64'(o_stb), 64'h2);
        m_cyc = 1'b0; m_stb = 1'b0;
        step();
        check("abort_cyc_after", 64'(o_cyc), 64'h0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            seen += int'(o_ack) + int'(o_err) + int'(o_evt);
            step();
        end
        check("abort_no_resp", 64'(seen), 64'h0);

        // Reset while an access is in progress.
        m_adr = 32'h3000_0000; m_cyc = 1'b1; m_stb = 1'b1;
        step(); step();
        check("rstmid_stb_before", 64'(o_stb), 64'h1);
        rst = 1'b1;
        step();
        check("rstmid_outputs", {ifa.m_ack_o, ifa.m_err_o, ifa.m_dat_o, ifa.s_cyc_o, ifa.s_stb_o,
                                 evt_a, ifa.s_we_o, ifa.s_adr_o[31:0]}, 64'h0);
        m_cyc = 1'b0; m_stb = 1'b0; rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen += int'(o_ack) + int'(o_err) + $countones(o_cyc);
        end
        check("rstmid_no_resp", 64'(seen), 64'h0);

        // Randomised accesses with noise on the other slaves' ack/err.
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 4; i++) s_dat[i*32 +: 32] = $urandom;
            slot = $urandom_range(0, 6);
            radr = (slot == 6) ? 32'h2FFF_F000 : 32'h3000_0000 + (32'(slot) << 12);
            radr = radr | (32'($urandom) & 32'h0000_0FFC);
            txn($sformatf("rnd%0d", t), radr, 1'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 10), 40, 1'b1);
        end

        // 16-slot instance, watchdog disabled.
        use_b = 1'b1;
        for (int i = 0; i < 16; i++) s_dat[i*32 +: 32] = 32'(i);
        for (int i = 0; i < 16; i++)
            txn($sformatf("b_rd%0d", i), 32'h3000_0000 + (32'(i) << 12) + 32'(4 * i), 1'b0, 0,
                $urandom_range(0, 2), 20, 1'b1);
        txn("b_slow1000", 32'h3000_5000, 1'b0, 0, 1000, 1100, 1'b0);
        txn("b_unmapped", 32'h3001_0000, 1'b0, 0, 0, 20, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
